phase_freq_est: RTL and testbench
=================================

// Module: phase_freq_est
// PURPOSE
//  Sits directly downstream of the CORDIC arctan stage and consumes its angle results.
//  Angle scale: 0x7fff ~ +pi, 0x8000 ~ -pi.
//  Per result: forms the wrapped phase delta to the previous angle, accumulates an unwrapped phase, and
//  averages every 2^LOG2_N deltas into a frequency estimate (phase units per sample).
//  The estimate is presented on a valid/ready output held in a one-entry register.
// PARAMETERS
//  W       16  angle/delta/frequency width (two's complement, modular)
//  LOG2_N  3   log2 of deltas per average window (N = 8)
//  UW      32  unwrapped-phase accumulator width
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous, active-low reset
//  arctan_in    in   W   signed angle from CORDIC; stable while arctan_valid high
//  arctan_valid in   1   level; each 0->1 transition marks one new sample
//  clear        in   1   synchronous restart; discards history
//  freq_out     out  W   signed averaged phase delta
//  freq_valid   out  1   freq_out holds an unconsumed result
//  freq_ready   in   1   consumer accepts when freq_valid & freq_ready at a clk edge
//  phase_unw    out  UW  signed unwrapped phase, sum of first angle + all deltas
//  overrun      out  1   sticky: an unconsumed result was overwritten
// BEHAVIOUR
//  Reset (rst=0, async):
//   - freq_out=0, freq_valid=0, phase_unw=0, overrun=0; state=S_EMPTY; cnt=0; sum=0; prev=0.
//   - valid_q=1, so a level held high across reset is not counted.
//  Sample strobe:
//   - valid_q <= arctan_valid every edge; stb = arctan_valid & ~valid_q.
//   - All updates occur on the same edge that sees stb (no added latency).
//  Arithmetic:
//   - delta = arctan_in - prev, truncated to W bits; the wrap across +-pi is automatic.
//   - sum is W+LOG2_N bits signed, fed with sign-extended delta.
//   - result = (sum + delta) >>> LOG2_N, truncated toward -inf, low W bits.
//   - phase_unw accumulates sign-extended values and wraps mod 2^UW silently.
//  States:
//   - S_EMPTY: on stb -> prev<=arctan_in, phase_unw<=sext(arctan_in), cnt=0, sum=0 -> S_ACC.
//   - S_ACC: on stb -> prev<=arctan_in, phase_unw+=sext(delta).
//       - If cnt==N-1: load output with result, sum<=0, cnt<=0.
//       - Otherwise: sum+=delta, cnt++.
//       - Stay in S_ACC.
//   - No stb: all registers hold.
//  Output register:
//   - Load with freq_valid=0: freq_valid<=1.
//   - Load with freq_valid=1 & freq_ready=1: new value, freq_valid stays 1, no overrun.
//   - Load with freq_valid=1 & freq_ready=0: overwrite, overrun<=1.
//   - No load with freq_valid & freq_ready: freq_valid<=0; freq_out holds its value.
//  clear:
//   - Priority over stb; a sample coinciding with clear is dropped.
//   - Effect: state=S_EMPTY, cnt=0, sum=0, phase_unw=0, freq_valid=0, overrun=0, freq_out=0.
//   - valid_q still tracks arctan_valid.
//  First sample: yields no delta; the first result needs N+1 samples, later results need N.
// TESTING
//  T1 ramp: 9 samples 0x0000,0x1000..0x8000, freq_ready=1 -> freq_valid on 9th stb edge.
//     freq_out=0x1000; phase_unw=0x00008000.
//  T2 wrap: 9 samples from 0x7000 in +0x2000 steps (0x7000,0x9000,..) -> freq_out=0x2000.
//     phase_unw=0x00017000; no sign glitch at +-pi.
//  T3 negative: 9 samples from 0x0400 in -0x0800 steps -> freq_out=0xF800.
//     phase_unw=0xFFFFC400.
//  T4 backpressure: freq_ready=0 over 17 samples -> 2nd result overwrites, overrun=1.
//     Then freq_ready=1 for one edge -> freq_valid=0 next cycle; overrun stays 1.
//  T5 clear: pulse clear after 4 samples -> outputs zeroed; 9 further samples give one result.
//     A stb coincident with clear is not counted.
//  T6 reset: arctan_valid held 1 across rst release -> no sample until it toggles.
//     rst asserted mid-window -> all outputs 0 asynchronously, before the next clk.

Source files
------------

// File: rtl/phase_freq_est.sv
// Phase-to-frequency estimator behind the CORDIC arctan stage: wraps angle deltas,
// keeps an unwrapped phase and averages every 2^LOG2_N deltas into a frequency word.
module phase_freq_est #(
  parameter int W      = 16,
  parameter int LOG2_N = 3,
  parameter int UW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  arctan_in,
  input  logic          arctan_valid,
  input  logic          clear,
  output logic [W-1:0]  freq_out,
  output logic          freq_valid,
  input  logic          freq_ready,
  output logic [UW-1:0] phase_unw,
  output logic          overrun
);

  localparam int SW = W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_ACC = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [W-1:0]        prev_q, prev_d;
  logic [UW-1:0]       phase_q, phase_d;
  logic [W-1:0]        freq_q, freq_d;
  logic                fvalid_q, fvalid_d;
  logic                overrun_q, overrun_d;

  logic                stb_s;
  logic                load_s;
  logic [W-1:0]        delta_s;
  logic [SW-1:0]       sum_next_s;
  logic [W-1:0]        result_s;

  // Edge-detect the valid level and form the modular delta and window average.
  always_comb begin
    stb_s      = arctan_valid & ~valid_q;
    delta_s    = arctan_in - prev_q;
    sum_next_s = sum_q + {{LOG2_N{delta_s[W-1]}}, delta_s};
    // Arithmetic shift then truncation to W bits is just the upper slice.
    result_s   = sum_next_s[SW-1:LOG2_N];
  end

  // Next-state logic for the accumulator FSM and the one-entry output register.
  always_comb begin
    state_d   = state_q;
    valid_d   = arctan_valid;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    prev_d    = prev_q;
    phase_d   = phase_q;
    freq_d    = freq_q;
    fvalid_d  = fvalid_q;
    overrun_d = overrun_q;
    load_s    = 1'b0;

    if (clear) begin
      state_d   = S_EMPTY;
      cnt_d     = {LOG2_N{1'b0}};
      sum_d     = {SW{1'b0}};
      phase_d   = {UW{1'b0}};
      freq_d    = {W{1'b0}};
      fvalid_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (stb_s) begin
        case (state_q)
          S_EMPTY: begin
            prev_d  = arctan_in;
            phase_d = {{(UW-W){arctan_in[W-1]}}, arctan_in};
            cnt_d   = {LOG2_N{1'b0}};
            sum_d   = {SW{1'b0}};
            state_d = S_ACC;
          end
          S_ACC: begin
            prev_d  = arctan_in;
            phase_d = phase_q + {{(UW-W){delta_s[W-1]}}, delta_s};
            if (cnt_q == CNT_LAST) begin
              load_s = 1'b1;
              sum_d  = {SW{1'b0}};
              cnt_d  = {LOG2_N{1'b0}};
            end else begin
              sum_d  = sum_next_s;
              cnt_d  = cnt_q + {{(LOG2_N-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_d = S_EMPTY;
          end
        endcase
      end else begin
        state_d = state_q;
      end

      if (load_s) begin
        freq_d   = result_s;
        fvalid_d = 1'b1;
        if (fvalid_q && !freq_ready) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end else if (fvalid_q && freq_ready) begin
        fvalid_d = 1'b0;
      end else begin
        fvalid_d = fvalid_q;
      end
    end
  end

  // State registers; valid_q resets high so a level held across reset is not a sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_EMPTY;
      valid_q   <= 1'b1;
      cnt_q     <= {LOG2_N{1'b0}};
      sum_q     <= {SW{1'b0}};
      prev_q    <= {W{1'b0}};
      phase_q   <= {UW{1'b0}};
      freq_q    <= {W{1'b0}};
      fvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      prev_q    <= prev_d;
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      fvalid_q  <= fvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign freq_out   = freq_q;
  assign freq_valid = fvalid_q;
  assign phase_unw  = phase_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_phase_freq_est.sv
// Scoreboard bench for phase_freq_est: a reference model computes averages from
// whole windows of wrapped deltas; a monitor pops and compares on each handshake.
module tb_phase_freq_est;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] arctan_in = 16'h0000;
  logic        arctan_valid = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] freq_out;
  logic        freq_valid;
  logic        freq_ready = 1'b1;
  logic [31:0] phase_unw;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          have_prev = 1'b0;
  logic [15:0] prev_m = 16'h0000;
  logic [31:0] phase_m = 32'h0;
  int          dl[$];
  logic [15:0] exp_q[$];
  logic        exp_ov = 1'b0;

  phase_freq_est #(.W(16), .LOG2_N(3), .UW(32)) dut (
    .clk(clk), .rst(rst), .arctan_in(arctan_in), .arctan_valid(arctan_valid),
    .clear(clear), .freq_out(freq_out), .freq_valid(freq_valid),
    .freq_ready(freq_ready), .phase_unw(phase_unw), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    have_prev = 1'b0;
    dl.delete();
    phase_m = 32'h0;
    exp_q.delete();
    exp_ov = 1'b0;
  endtask

  // One sample: raise valid for one cycle, update the model, then idle cycles.
  task automatic send(input logic [15:0] a, input int idle);
    logic signed [15:0] d;
    int s;
    @(negedge clk); #1;
    arctan_in = a;
    arctan_valid = 1'b1;
    if (!have_prev) begin
      prev_m = a;
      phase_m = {{16{a[15]}}, a};
      have_prev = 1'b1;
      dl.delete();
    end else begin
      d = a - prev_m;
      phase_m = phase_m + {{16{d[15]}}, d};
      prev_m = a;
      dl.push_back(int'(d));
      if (dl.size() == 8) begin
        s = 0;
        foreach (dl[i]) s += dl[i];
        s = s >>> 3;
        if (!freq_ready && exp_q.size() > 0) begin
          exp_q[exp_q.size()-1] = 16'(s);
          exp_ov = 1'b1;
        end else begin
          exp_q.push_back(16'(s));
        end
        dl.delete();
      end
    end
    @(negedge clk); #1;
    arctan_valid = 1'b0;
    repeat (idle) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_clear(input bit with_stb);
    @(negedge clk); #1;
    clear = 1'b1;
    if (with_stb) begin
      arctan_in = 16'h4321;
      arctan_valid = 1'b1;
    end
    model_reset();
    @(negedge clk); #1;
    clear = 1'b0;
    arctan_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_freq_out"}, {16'h0, freq_out}, 32'h0);
    check({nm, "_freq_valid"}, {31'h0, freq_valid}, 32'h0);
    check({nm, "_phase_unw"}, phase_unw, 32'h0);
    check({nm, "_overrun"}, {31'h0, overrun}, 32'h0);
  endtask

  // Monitor: compare on every accepted output, well away from the clock edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk); #3;
      if (rst && freq_valid && freq_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {16'h0, freq_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("freq_out", {16'h0, freq_out}, {16'h0, e});
        end
      end
    end
  end

  initial begin
    // T6a: reset values, and a valid level held across release is not a sample
    arctan_in = 16'h1234;
    arctan_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("held_valid_phase", phase_unw, 32'h0);
    arctan_valid = 1'b0;
    @(negedge clk); #1;

    // T1 ramp
    do_clear(1'b0);
    for (int i = 0; i < 9; i++) send(16'(i * 16'h1000), 0);
    check("t1_phase", phase_unw, phase_m);
    check("t1_phase_const", phase_unw, 32'h0000_8000);

    // T2 wrap across +-pi
    do_clear(1'b0);
    for (int i = 0; i < 9; i++) send(16'(16'h7000 + i * 16'h2000), 0);
    check("t2_phase_const", phase_unw, 32'h0001_7000);

    // T3 negative steps
    do_clear(1'b0);
    for (int i = 0; i < 9; i++) send(16'(16'h0400 - i * 16'h0800), 1);
    check("t3_phase_const", phase_unw, 32'hFFFF_C400);

    // T4 backpressure: second result overwrites the first
    do_clear(1'b0);
    freq_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(16'(i * 16'h0300 + 16'h0010), 0);
    check("t4_overrun", {31'h0, overrun}, {31'h0, exp_ov});
    check("t4_overrun_const", {31'h0, overrun}, 32'h1);
    check("t4_valid_held", {31'h0, freq_valid}, 32'h1);
    @(negedge clk); #1;
    freq_ready = 1'b1;
    @(negedge clk); #1;
    freq_ready = 1'b0;
    #2;
    check("t4_valid_drop", {31'h0, freq_valid}, 32'h0);
    check("t4_overrun_sticky", {31'h0, overrun}, 32'h1);
    freq_ready = 1'b1;

    // T5 clear mid-window with a coincident strobe
    do_clear(1'b0);
    for (int i = 0; i < 4; i++) send(16'(i * 16'h0500), 0);
    do_clear(1'b1);
    check_zero("t5_clear");
    for (int i = 0; i < 9; i++) send(16'(16'hF000 + i * 16'h0123), 0);
    check("t5_phase", phase_unw, phase_m);

    // Random angles with random spacing
    do_clear(1'b0);
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), $urandom_range(0, 2));
      if (i % 10 == 9) check("rand_phase", phase_unw, phase_m);
    end
    // Random ramp, so averages are exercised with non-trivial steps
    begin
      logic [15:0] base, step;
      base = 16'($urandom);
      step = 16'($urandom);
      for (int i = 0; i < 17; i++) send(16'(base + i * step), 0);
      check("ramp_phase", phase_unw, phase_m);
    end

    // T6b: async reset mid-window with a pending result
    do_clear(1'b0);
    freq_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(16'(i * 16'h0777), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_zero("t6_async_rst");
    @(negedge clk); #1;
    rst = 1'b1;
    freq_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check("drain", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
